imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter MAX_WORDS, default 256, giving the maximum program length in 32-bit words (legal range 1..65535).
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a load; sampled on a rising edge.
REQ-005 byte_valid  input  1  byte_data is valid this cycle.
REQ-006 byte_data  input  8  incoming stream byte.
REQ-007 byte_ready  output  1  the loader accepts a byte this cycle.
REQ-008 imem_we  output  1  one-cycle write strobe to the instruction memory.
REQ-009 imem_addr  output  32  byte address of the write; always a multiple of 4.
REQ-010 imem_wdata  output  32  instruction word to write.
REQ-011 cpu_reset  output  1  holds the processor in reset while high.
REQ-012 done  output  1  the load completed with a valid checksum.
REQ-013 error  output  1  the load was aborted.

Function
REQ-014 A byte SHALL be accepted only on a rising edge where byte_valid and byte_ready are both 1; byte_data SHALL be ignored otherwise.
REQ-015 Stream format: LEN_HI, LEN_LO (N = {LEN_HI,LEN_LO}), then 4N data bytes with each word big-endian (first byte goes to [31:24]), then one checksum byte equal to the XOR of all 4N data bytes (header excluded).
REQ-016 FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
REQ-017 byte_ready SHALL be 1 exactly in LEN_HI, LEN_LO, DATA and CHECK, and SHALL be driven from state only (registered), with no combinational dependence on byte_valid.
REQ-018 A start pulse in IDLE, DONE or ERROR SHALL transition to LEN_HI on that edge; it SHALL clear done, clear error, set cpu_reset to 1, and clear the word index and checksum accumulator. start SHALL be ignored in LEN_HI, LEN_LO, DATA and CHECK.
REQ-019 Accepting a byte in LEN_HI SHALL transition to LEN_LO.
REQ-020 Accepting a byte in LEN_LO SHALL transition to ERROR if N==0 or N>MAX_WORDS, and to DATA otherwise.
REQ-021 In DATA, a 2-bit byte counter SHALL track the byte position; each accepted byte SHALL be shifted into the word register and XORed into the 8-bit checksum accumulator.
REQ-022 On acceptance of the 4th byte of a word, imem_we SHALL be 1 for exactly the following cycle, with imem_wdata equal to the assembled word and imem_addr equal to {word_index,2'b00} zero-extended to 32 bits; word_index SHALL then increment.
REQ-023 word_index SHALL be 16 bits wide; the first word SHALL be written to address 0, and addresses SHALL increase by 4 per word with no wrap-around within a legal N.
REQ-024 After the write of word N-1, the FSM SHALL enter CHECK; this write SHALL still occur in the cycle after the last data byte.
REQ-025 Accepting a byte in CHECK SHALL transition to DONE if it equals the accumulator, and to ERROR otherwise.
REQ-026 In DONE: done=1, cpu_reset=0, error=0. In ERROR: error=1, done=0, cpu_reset=1. Both states SHALL be held until start or reset.
REQ-027 imem_addr and imem_wdata SHALL hold their last values while imem_we=0.
REQ-028 Idle cycles between bytes (byte_valid=0) SHALL not change state, counters or accumulator.

Reset
REQ-029 While reset=1 (asynchronously, including in the middle of any state), the state SHALL be IDLE and the outputs SHALL be: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0. All counters and the accumulator SHALL be 0.
REQ-030 After reset is released, the loader SHALL remain in IDLE with cpu_reset=1 until start is asserted.

Verification
REQ-031 Assert and release reset -> byte_ready=0, imem_we=0, cpu_reset=1, done=0, error=0; a byte presented with byte_valid=1 and no start is not accepted.
REQ-032 start, then bytes 00 02 20 08 00 05 8C 09 00 04 AC -> writes (addr 0x0, data 0x20080005) and (addr 0x4, data 0x8C090004), each one cycle wide; then done=1, cpu_reset=0.
REQ-033 The same stream with checksum byte 0xAD -> both writes occur, then error=1, done=0, cpu_reset=1; a new start clears error.
REQ-034 Header 00 00, and separately header 01 01 (257) with MAX_WORDS=256 -> error=1 immediately after the LEN_LO byte, and no imem_we is issued.
REQ-035 Assert reset asynchronously after the 5th byte of REQ-032 -> IDLE and imem_we=0 immediately; a full reload then writes first to address 0x0 with correct data.
REQ-036 REQ-032 with random byte_valid gaps and a start pulse during DATA -> results identical to REQ-032, and the start pulse has no effect.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed, XOR-checksummed byte stream
// into 32-bit big-endian words and writes them to IMEM while holding the CPU in reset.
module imem_loader #(
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    logic [15:0] len;
    logic [15:0] word_index;
    logic [1:0]  byte_cnt;
    logic [23:0] word_reg;
    logic [7:0]  csum;

    logic        accept_c;
    logic [15:0] len_c;
    logic        len_bad_c;

    assign accept_c  = byte_valid && byte_ready;
    assign len_c     = {len[15:8], byte_data};
    assign len_bad_c = (len_c == 16'd0) || (17'(len_c) > 17'(MAX_WORDS));

    // Only the first three bytes of a word are buffered; the fourth goes straight to imem_wdata.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            len        <= 16'd0;
            word_index <= 16'd0;
            byte_cnt   <= 2'd0;
            word_reg   <= 24'd0;
            csum       <= 8'd0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state      <= S_LEN_HI;
                        byte_ready <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        cpu_reset  <= 1'b1;
                        word_index <= 16'd0;
                        byte_cnt   <= 2'd0;
                        csum       <= 8'd0;
                    end
                end
                S_LEN_HI: begin
                    if (accept_c) begin
                        len[15:8] <= byte_data;
                        state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept_c) begin
                        len <= len_c;
                        if (len_bad_c) begin
                            state      <= S_ERROR;
                            byte_ready <= 1'b0;
                            error      <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept_c) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        csum     <= csum ^ byte_data;
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {word_reg, byte_data};
                            imem_addr  <= {14'd0, word_index, 2'b00};
                            word_index <= word_index + 16'd1;
                            if (word_index == len - 16'd1) begin
                                state <= S_CHECK;
                            end
                        end else begin
                            word_reg <= {word_reg[15:0], byte_data};
                        end
                    end
                end
                S_CHECK: begin
                    if (accept_c) begin
                        byte_ready <= 1'b0;
                        if (byte_data == csum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
